led_strip_rx: RTL and testbench
===============================

LED_STRIP_RX -- requirements
Module: led_strip_rx

Interface
REQ-001 Parameter NUM_LEDS, default 64, meaning LED words per frame; legal range 1..64.
REQ-002 Parameter TIMEOUT, default 4095, meaning max clk cycles between led_clk falling edges while mid-frame; legal range 2..4095.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 led_clk  input  1  serial LED-strip clock from the matrix driver.
REQ-006 led_data  input  1  serial LED-strip data; changes coincident with led_clk rising.
REQ-007 pix_valid  output  1  one-cycle pulse, decoded LED word available.
REQ-008 pix_index  output  6  LED position 0..NUM_LEDS-1 within the frame.
REQ-009 pix_bright  output  5  word bits [28:24].
REQ-010 pix_blue, pix_green, pix_red  output  8 each  word bits [23:16], [15:8], [7:0].
REQ-011 frame_done  output  1  one-cycle pulse after the last LED word of a frame.
REQ-012 frame_err  output  1  one-cycle pulse on header error or timeout.

Function
REQ-013 led_clk and led_data each pass through an identical two-flop synchronizer before use.
REQ-014 Bit sample event ("fall"): synchronized led_clk was 1 the previous cycle and is 0 this cycle; led_data sampled in that same cycle; no other sampling.
REQ-015 Words are MSB first, 32 bits: [31:29] header, [28:24] brightness, then blue, green, red.
REQ-016 FSM states: HUNT, WAIT_HDR, WORD.
REQ-017 HUNT: 6-bit zero counter increments per fall with data 0, clears per fall with data 1; at 32 consecutive zeros go to WAIT_HDR.
REQ-018 WAIT_HDR: falls with data 0 are ignored (end-frame/extra zeros); first fall with data 1 enters WORD with that bit as word bit 31 and bit count 1.
REQ-019 WORD: shift one bit per fall; on the 32nd bit check header: 3'b111 -> publish word, else frame_err and go HUNT with no pix_valid.
REQ-020 Publish: output fields register the word, pix_valid high exactly one cycle, asserted the cycle after the 32nd fall; fields hold until next publish.
REQ-021 pix_index = count of words already published in the current frame; first word of frame is 0.
REQ-022 After word NUM_LEDS-1 is published: frame_done pulses in the same cycle as that pix_valid, word counter clears, FSM goes HUNT.
REQ-023 Otherwise after a good word, FSM returns to WAIT_HDR... no: stays in WORD expecting next word's bit 31 on next fall, bit count 0.
REQ-024 Timeout: in WAIT_HDR or WORD, cycle counter clears on each fall, increments otherwise; reaching TIMEOUT pulses frame_err, clears word counter, goes HUNT. No timeout in HUNT.
REQ-025 Header error or timeout discards the partial frame; no frame_done for it.
REQ-026 frame_err and pix_valid never pulse in the same cycle.

Reset
REQ-027 Reset forces HUNT, clears all counters, shift register and synchronizers; pix_valid, frame_done, frame_err 0; pix_index, pix_bright, pix_blue, pix_green, pix_red 0.
REQ-028 Reset mid-word or mid-frame abandons it without any pulse; decoding restarts only after a fresh 32-zero start frame.

Verification
REQ-029 32 zeros then 64 words 0xF0000F00 -> 64 pix_valid pulses, pix_index 0..63, bright 16, green 0x0F, blue 0, red 0; frame_done with the index-63 pulse; no frame_err.
REQ-030 Start frame of 31 zeros then words -> no pix_valid until a later run of 32 zeros; then decoding resumes at index 0.
REQ-031 Valid start, word 0xF0070000, then word 0xD0070000 -> one pix_valid (blue 0x07, index 0), then frame_err pulse, no further pix_valid until a new start frame.
REQ-032 Start frame, 10 bits of a word, led_clk held low TIMEOUT cycles -> exactly one frame_err at cycle TIMEOUT after last fall; FSM in HUNT.
REQ-033 Reset asserted during word 5 of a frame -> all outputs 0 next cycle, no pulses; the following full frame decodes indices 0..63.
REQ-034 Two back-to-back frames separated by 64 zeros (end frame + start frame) -> two frame_done pulses, 128 pix_valid total.

Source files
------------

// File: rtl/led_strip_rx.sv
// led_strip_rx
//   Decodes a serial APA102-style LED-strip stream (led_clk / led_data) into
//   per-LED words. A frame starts with 32 zero bits, followed by NUM_LEDS
//   32-bit words (3'b111 header, 5-bit brightness, blue, green, red), MSB first.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   led_clk, led_data asynchronous serial strip inputs (bit taken on led_clk fall)
//   pix_valid         one-cycle pulse, word fields below are new
//   pix_index         LED position of the published word within the frame
//   pix_bright/blue/green/red  decoded word fields, held until next publish
//   frame_done        one-cycle pulse with the last word of a frame
//   frame_err         one-cycle pulse on bad header or inter-bit timeout
module led_strip_rx #(
   parameter int NUM_LEDS = 64,
   parameter int TIMEOUT  = 4095
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       led_clk,
   input  logic       led_data,
   output logic       pix_valid,
   output logic [5:0] pix_index,
   output logic [4:0] pix_bright,
   output logic [7:0] pix_blue,
   output logic [7:0] pix_green,
   output logic [7:0] pix_red,
   output logic       frame_done,
   output logic       frame_err
);

   localparam logic [5:0]  LAST_IDX = 6'(NUM_LEDS - 1);
   localparam logic [12:0] TMO_VAL  = 13'(TIMEOUT);

   typedef enum logic [1:0] {HUNT, WAIT_HDR, WORD} state_t;

   state_t      state_q, state_d;

   logic        lclk_s1_q, lclk_s2_q, lclk_prev_q;
   logic        ldat_s1_q, ldat_s2_q;
   logic [5:0]  zcnt_q;
   logic [4:0]  bcnt_q;
   logic [30:0] shift_q;
   logic [5:0]  wcnt_q;
   logic [11:0] tcnt_q;

   logic        pix_valid_q, frame_done_q, frame_err_q;
   logic [5:0]  pix_index_q;
   logic [4:0]  pix_bright_q;
   logic [7:0]  pix_blue_q, pix_green_q, pix_red_q;

   logic        fall, bit_in;
   logic [31:0] word_full;

   // control strobes decoded from the FSM state
   logic        start_seen, last_bit, publish, hdr_err, last_word, tmo;

   assign fall      = lclk_prev_q & ~lclk_s2_q;
   assign bit_in    = ldat_s2_q;
   // the 32nd bit completes the word straight from the shifter
   assign word_full = {shift_q, bit_in};

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= HUNT;
      else       state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT:     if (start_seen)                    state_d = WAIT_HDR;
         WAIT_HDR: if (tmo)                           state_d = HUNT;
                   else if (fall && bit_in)           state_d = WORD;
         WORD:     if (tmo || hdr_err || last_word)   state_d = HUNT;
         default:                                     state_d = HUNT;
      endcase
   end

   // FSM output decode
   always_comb begin
      start_seen = (state_q == HUNT) && fall && !bit_in && (zcnt_q == 6'd31);
      last_bit   = (state_q == WORD) && fall && (bcnt_q == 5'd31);
      publish    = last_bit && (word_full[31:29] == 3'b111);
      hdr_err    = last_bit && (word_full[31:29] != 3'b111);
      last_word  = publish && (wcnt_q == LAST_IDX);
      // timeout counts idle cycles since the last fall; widened to avoid wrap
      tmo        = (state_q != HUNT) && !fall && (({1'b0, tcnt_q} + 13'd1) == TMO_VAL);
   end

   // datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         lclk_s1_q    <= 1'b0;
         lclk_s2_q    <= 1'b0;
         lclk_prev_q  <= 1'b0;
         ldat_s1_q    <= 1'b0;
         ldat_s2_q    <= 1'b0;
         zcnt_q       <= '0;
         bcnt_q       <= '0;
         shift_q      <= '0;
         wcnt_q       <= '0;
         tcnt_q       <= '0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         pix_index_q  <= '0;
         pix_bright_q <= '0;
         pix_blue_q   <= '0;
         pix_green_q  <= '0;
         pix_red_q    <= '0;
      end else begin
         lclk_s1_q    <= led_clk;
         lclk_s2_q    <= lclk_s1_q;
         lclk_prev_q  <= lclk_s2_q;
         ldat_s1_q    <= led_data;
         ldat_s2_q    <= ldat_s1_q;

         pix_valid_q  <= publish;
         frame_done_q <= last_word;
         frame_err_q  <= hdr_err | tmo;

         if (publish) begin
            pix_index_q  <= wcnt_q;
            pix_bright_q <= word_full[28:24];
            pix_blue_q   <= word_full[23:16];
            pix_green_q  <= word_full[15:8];
            pix_red_q    <= word_full[7:0];
         end

         if (hdr_err || tmo || last_word) wcnt_q <= '0;
         else if (publish)                wcnt_q <= wcnt_q + 6'd1;

         // run of consecutive zero bits, only meaningful while hunting
         if (state_q != HUNT || start_seen) zcnt_q <= '0;
         else if (fall)                     zcnt_q <= bit_in ? 6'd0 : zcnt_q + 6'd1;

         if (state_q == HUNT || fall) tcnt_q <= '0;
         else                         tcnt_q <= tcnt_q + 12'd1;

         // the shifter runs freely; only the last 31 bits matter at word end
         case (state_q)
            WAIT_HDR: if (fall && bit_in) begin
                         bcnt_q  <= 5'd1;
                         shift_q <= {shift_q[29:0], bit_in};
                      end
            WORD:     if (fall) begin
                         bcnt_q  <= bcnt_q + 5'd1;
                         shift_q <= {shift_q[29:0], bit_in};
                      end
            default:  bcnt_q <= '0;
         endcase
      end
   end

   assign pix_valid  = pix_valid_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign pix_index  = pix_index_q;
   assign pix_bright = pix_bright_q;
   assign pix_blue   = pix_blue_q;
   assign pix_green  = pix_green_q;
   assign pix_red    = pix_red_q;

endmodule

// File: tb/tb_led_strip_rx.sv
module tb_led_strip_rx;
   localparam int NUM_LEDS = 64;
   localparam int TIMEOUT  = 4095;

   logic       clk = 1'b0;
   logic       reset, led_clk, led_data;
   logic       pix_valid, frame_done, frame_err;
   logic [5:0] pix_index;
   logic [4:0] pix_bright;
   logic [7:0] pix_blue, pix_green, pix_red;

   always #5 clk = ~clk;

   led_strip_rx #(.NUM_LEDS(NUM_LEDS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .led_clk(led_clk), .led_data(led_data),
      .pix_valid(pix_valid), .pix_index(pix_index), .pix_bright(pix_bright),
      .pix_blue(pix_blue), .pix_green(pix_green), .pix_red(pix_red),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   int vectors = 0, miscompares = 0;
   bit chk_en = 1'b0;
   int pv_cnt = 0, fd_cnt = 0, fe_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Inputs are seen through two sync stages plus an edge-detect stage, so a
   // bit decision reflects the led_clk samples of three and two edges ago and
   // lands in the outputs at the current edge.
   logic       h_c1 = 0, h_c2 = 0, h_c3 = 0, h_d1 = 0, h_d2 = 0;
   int         m_mode = 0;           // 0 looking for start, 1 awaiting header, 2 in word
   int         m_zeros = 0, m_nb = 0, m_idle = 0, m_widx = 0;
   logic [31:0] m_word = 0;
   logic       m_valid = 0, m_done = 0, m_err = 0;
   logic [5:0] m_idx = 0;
   logic [4:0] m_bright = 0;
   logic [7:0] m_blue = 0, m_green = 0, m_red = 0;

   always @(posedge clk) begin
      logic fell, b;
      if (reset) begin
         h_c1 = 0; h_c2 = 0; h_c3 = 0; h_d1 = 0; h_d2 = 0;
         m_mode = 0; m_zeros = 0; m_nb = 0; m_idle = 0; m_widx = 0; m_word = 0;
         m_valid = 0; m_done = 0; m_err = 0;
         m_idx = 0; m_bright = 0; m_blue = 0; m_green = 0; m_red = 0;
      end else begin
         fell = h_c3 & ~h_c2;
         b    = h_d2;
         m_valid = 0; m_done = 0; m_err = 0;
         if (fell) begin
            m_idle = 0;
            if (m_mode == 0) begin
               m_zeros = b ? 0 : m_zeros + 1;
               if (m_zeros == 32) begin m_mode = 1; m_zeros = 0; end
            end else if (m_mode == 1) begin
               if (b) begin m_word = 32'd1; m_nb = 1; m_mode = 2; end
            end else begin
               m_word = {m_word[30:0], b};
               m_nb++;
               if (m_nb == 32) begin
                  m_nb = 0;
                  if (m_word[31:29] == 3'b111) begin
                     m_valid = 1; m_idx = 6'(m_widx);
                     m_bright = m_word[28:24]; m_blue = m_word[23:16];
                     m_green = m_word[15:8]; m_red = m_word[7:0];
                     m_widx++;
                     if (m_widx == NUM_LEDS) begin m_done = 1; m_widx = 0; m_mode = 0; m_zeros = 0; end
                  end else begin
                     m_err = 1; m_widx = 0; m_mode = 0; m_zeros = 0;
                  end
               end
            end
         end else if (m_mode != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin m_err = 1; m_widx = 0; m_mode = 0; m_zeros = 0; m_idle = 0; end
         end
         h_c3 = h_c2; h_c2 = h_c1; h_c1 = led_clk;
         h_d2 = h_d1; h_d1 = led_data;
      end
   end

   // ---------------- per-cycle compare and pulse monitor ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("outputs", {26'd0, pix_valid, frame_done, frame_err, pix_index, pix_bright, pix_blue, pix_green, pix_red},
                        {26'd0, m_valid, m_done, m_err, m_idx, m_bright, m_blue, m_green, m_red});
         if (pix_valid === 1'b1 && frame_err === 1'b1) chk("valid_and_err", 1, 0);
         if (pix_valid)  pv_cnt++;
         if (frame_done) fd_cnt++;
         if (frame_err)  fe_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      led_data = b;
      led_clk  = 1'b1;
      idle($urandom_range(1, 2));
      led_clk  = 1'b0;
      idle($urandom_range(1, 2));
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   function automatic logic [31:0] rword();
      logic [31:0] r;
      r = $urandom();
      r[31:29] = 3'b111;
      return r;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      #(10 * 95000);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int pv0, fd0, fe0, n;
      logic [31:0] w;
      reset = 1'b1; led_clk = 1'b0; led_data = 1'b0;
      idle(3);
      chk("reset_state", {26'd0, pix_valid, frame_done, frame_err, pix_index, pix_bright, pix_blue, pix_green, pix_red}, 64'd0);
      chk_en = 1'b1;
      reset = 1'b0;

      // full frame of identical words
      pv0 = pv_cnt; fd0 = fd_cnt; fe0 = fe_cnt;
      send_zeros(32);
      for (int i = 0; i < NUM_LEDS; i++) send_word(32'hF0000F00);
      idle(10);
      chk("f1_pix_count", pv_cnt - pv0, 64);
      chk("f1_done_count", fd_cnt - fd0, 1);
      chk("f1_err_count", fe_cnt - fe0, 0);
      chk("f1_last_index", pix_index, 63);
      chk("f1_fields", {pix_bright, pix_blue, pix_green, pix_red}, {5'd16, 8'h00, 8'h0F, 8'h00});

      // short start frame must not sync
      do_reset();
      pv0 = pv_cnt;
      send_zeros(31);
      for (int i = 0; i < 3; i++) send_word(32'hF0000F00);
      idle(10);
      chk("short_start_no_pix", pv_cnt - pv0, 0);
      send_zeros(32);
      send_word(32'hF0000F00);
      send_word(32'hF0000F00);
      idle(10);
      chk("resync_pix_count", pv_cnt - pv0, 2);
      chk("resync_index", pix_index, 1);

      // bad header after one good word
      do_reset();
      pv0 = pv_cnt; fe0 = fe_cnt;
      send_zeros(32);
      send_word(32'hF0070000);
      send_word(32'hD0070000);
      send_word(32'hF0070000);
      idle(10);
      chk("hdr_pix_count", pv_cnt - pv0, 1);
      chk("hdr_err_count", fe_cnt - fe0, 1);
      chk("hdr_fields", {pix_index, pix_bright, pix_blue, pix_green, pix_red}, {6'd0, 5'd16, 8'h07, 8'h00, 8'h00});

      // timeout mid-word: latency from led_clk drop to frame_err
      do_reset();
      pv0 = pv_cnt; fe0 = fe_cnt;
      send_zeros(32);
      send_bit(1'b1);
      for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
      led_data = 1'b1; led_clk = 1'b1;
      idle(1);
      led_clk = 1'b0;
      n = 0;
      while (n < TIMEOUT + 50) begin
         @(negedge clk);
         n++;
         if (frame_err) break;
      end
      chk("tmo_latency", n, TIMEOUT + 3);
      idle(50);
      chk("tmo_err_count", fe_cnt - fe0, 1);
      send_word(32'hF0000F00);
      idle(10);
      chk("tmo_hunt_no_pix", pv_cnt - pv0, 0);
      send_zeros(32);
      send_word(32'hF0000F00);
      idle(10);
      chk("tmo_resync_index", {pv_cnt - pv0, 26'd0, pix_index}, {32'd1, 32'd0});

      // reset during word 5
      pv0 = pv_cnt;
      send_zeros(32);
      for (int i = 0; i < 5; i++) send_word(rword());
      w = rword();
      for (int i = 31; i >= 20; i--) send_bit(w[i]);
      reset = 1'b1;
      idle(1);
      chk("midreset_outputs", {26'd0, pix_valid, frame_done, frame_err, pix_index, pix_bright, pix_blue, pix_green, pix_red}, 64'd0);
      reset = 1'b0;
      pv0 = pv_cnt; fd0 = fd_cnt; fe0 = fe_cnt;
      send_zeros(32);
      for (int i = 0; i < NUM_LEDS; i++) send_word(rword());
      idle(10);
      chk("after_reset_frame", {pv_cnt - pv0, fd_cnt - fd0}, {32'd64, 32'd1});
      chk("after_reset_last_idx", pix_index, 63);

      // back-to-back frames
      pv0 = pv_cnt; fd0 = fd_cnt; fe0 = fe_cnt;
      send_zeros(32);
      for (int i = 0; i < NUM_LEDS; i++) send_word(rword());
      send_zeros(64);
      for (int i = 0; i < NUM_LEDS; i++) send_word(rword());
      idle(10);
      chk("b2b_pix_count", pv_cnt - pv0, 128);
      chk("b2b_done_count", fd_cnt - fd0, 2);
      chk("b2b_err_count", fe_cnt - fe0, 0);

      // random episodes, checked cycle by cycle against the model
      for (int e = 0; e < 16; e++) begin
         send_zeros($urandom_range(28, 34));
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            w = $urandom();
            if ($urandom_range(0, 5) != 0) w[31:29] = 3'b111;
            send_word(w);
         end
         if ($urandom_range(0, 3) == 0)
            for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) idle(TIMEOUT - 4 + $urandom_range(0, 6));
         else                           idle($urandom_range(0, 20));
      end
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
